// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for one shared combinational shifter.
// Two requesters feed an operand stage that drives the shifter. The shifter
// output is captured in a result stage that hands off to writeback with a
// valid/ready handshake.
module shift_arbiter #(
  parameter int XLEN         = 32,
  parameter int NB_OPERATION = 8,
  parameter int TAG_W        = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    req0_valid_i,
  output logic                    req0_ready_o,
  input  logic [XLEN-1:0]         req0_rs1_i,
  input  logic [XLEN-1:0]         req0_rs2_i,
  input  logic [NB_OPERATION-1:0] req0_cmd_i,
  input  logic [TAG_W-1:0]        req0_tag_i,
  input  logic                    req1_valid_i,
  output logic                    req1_ready_o,
  input  logic [XLEN-1:0]         req1_rs1_i,
  input  logic [XLEN-1:0]         req1_rs2_i,
  input  logic [NB_OPERATION-1:0] req1_cmd_i,
  input  logic [TAG_W-1:0]        req1_tag_i,
  output logic [XLEN-1:0]         sh_rs1_o,
  output logic [XLEN-1:0]         sh_rs2_o,
  output logic [NB_OPERATION-1:0] sh_cmd_o,
  output logic                    sh_en_o,
  input  logic [XLEN-1:0]         sh_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [XLEN-1:0]         res_data_o,
  output logic                    res_src_o,
  output logic [TAG_W-1:0]        res_tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]         rs1;
    logic [4:0]              amt;
    logic [NB_OPERATION-1:0] cmd;
    logic [TAG_W-1:0]        tag;
    logic                    src;
  } op_t;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic             src;
  } res_t;

  // Requester views as packed arrays so the winner is selected by index.
  logic [1:0]                         req_valid;
  logic [1:0][XLEN-1:0]               req_rs1;
  logic [1:0][4:0]                    req_amt;
  logic [1:0][NB_OPERATION-1:0]       req_cmd;
  logic [1:0][TAG_W-1:0]              req_tag;
  logic [1:0]                         ready;

  // Only the low five bits of the shift amount are architecturally meaningful.
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^{req0_rs2_i[XLEN-1:5], req1_rs2_i[XLEN-1:5]};

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign req_rs1   = {req1_rs1_i, req0_rs1_i};
  assign req_amt   = {req1_rs2_i[4:0], req0_rs2_i[4:0]};
  assign req_cmd   = {req1_cmd_i, req0_cmd_i};
  assign req_tag   = {req1_tag_i, req0_tag_i};

  logic op_v_q, op_v_d, res_v_q, res_v_d, prio_q, prio_d;
  op_t  op_q, op_d;
  res_t res_q, res_d;
  logic res_adv, res_free, op_adv, op_can, both, grant, accept;

  assign res_adv  = res_v_q & res_ready_i;
  assign res_free = ~res_v_q | res_adv;
  assign op_adv   = op_v_q & res_free;
  assign op_can   = ~op_v_q | op_adv;

  // Arbitration: tie goes to prio_q; readies stay low while reset is asserted.
  always_comb begin
    both  = &req_valid;
    grant = both ? prio_q : req_valid[1];
    ready = '0;
    if ((|req_valid) && op_can && !flush_i && reset_n) ready[grant] = 1'b1;
    accept = |ready;
  end

  // Next state for both pipeline stages and the round-robin pointer.
  always_comb begin
    op_v_d  = op_v_q;
    op_d    = op_q;
    res_v_d = res_v_q;
    res_d   = res_q;
    prio_d  = prio_q;
    if (flush_i) begin
      op_v_d  = 1'b0;
      res_v_d = 1'b0;
    end else begin
      if (op_adv) begin
        res_v_d    = 1'b1;
        res_d.data = sh_data_i;
        res_d.tag  = op_q.tag;
        res_d.src  = op_q.src;
      end else if (res_adv) begin
        res_v_d = 1'b0;
      end
      if (accept) begin
        op_v_d     = 1'b1;
        op_d.rs1   = req_rs1[grant];
        op_d.amt   = req_amt[grant];
        op_d.cmd   = req_cmd[grant];
        op_d.tag   = req_tag[grant];
        op_d.src   = grant;
        if (both) prio_d = ~prio_q;
      end else if (op_adv) begin
        op_v_d = 1'b0;
      end
    end
  end

  // State registers; reset clears valids, pointer and all payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_v_q  <= 1'b0;
      res_v_q <= 1'b0;
      prio_q  <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      op_v_q  <= op_v_d;
      res_v_q <= res_v_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign sh_rs1_o     = op_q.rs1;
  assign sh_rs2_o     = {{(XLEN-5){1'b0}}, op_q.amt};
  assign sh_cmd_o     = op_q.cmd;
  assign sh_en_o      = op_v_q;
  assign res_valid_o  = res_v_q;
  assign res_data_o   = res_q.data;
  assign res_tag_o    = res_q.tag;
  assign res_src_o    = res_q.src;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-stage issue/retire controller that shares the single combinational `shifter` datapath between two requesters: port 0 (main execute pipe) and port 1 (secondary issue port). It arbitrates round-robin, registers the winning operands into an operand stage that drives the shifter, and captures the shifter output into a result stage with a valid/ready handshake toward writeback. It sits between issue and writeback, wrapping the `shifter` instance.

## Interface
- XLEN, 32, data width (from riscv_pkg).
- NB_OPERATION, riscv_pkg value, width of the one-hot command vector.
- TAG_W, 4, width of the opaque requester tag carried with each operation.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight operations.
- reqN_valid_i  in  1  request valid, N = 0 or 1.
- reqN_ready_o  out  1  request accepted this cycle when valid & ready.
- reqN_rs1_i  in  XLEN  value to shift.
- reqN_rs2_i  in  XLEN  shift amount; only bits [4:0] are used.
- reqN_cmd_i  in  NB_OPERATION  one-hot command (SLL/SRL/SRA bits used).
- reqN_tag_i  in  TAG_W  tag returned with the result.
- sh_rs1_o  out  XLEN  operand-stage rs1 to the shifter.
- sh_rs2_o  out  XLEN  operand-stage rs2, bits [XLEN-1:5] forced to 0.
- sh_cmd_o  out  NB_OPERATION  operand-stage command.
- sh_en_o  out  1  shifter enable, equal to operand-stage valid.
- sh_data_i  in  XLEN  shifter result, combinational from the `sh_*` outputs.
- res_valid_o  out  1  result-stage valid.
- res_ready_i  in  1  consumer ready.
- res_data_o  out  XLEN  shifted result.
- res_src_o  out  1  winning port (0/1).
- res_tag_o  out  TAG_W  tag of the result.

## Operation
- State consists of two valid bits, `op_v` (operand stage) and `res_v` (result stage), plus the round-robin pointer `prio` (the port that wins a tie).
  - Combined states are EMPTY (0,0), ISSUED (1,0), DONE (0,1) and FULL (1,1).
- `res_adv` = `res_v` & `res_ready_i`.
- Result stage is free when `!res_v` or `res_adv`.
- `op_adv` = `op_v` & result stage free. The operand stage can accept when `!op_v` or `op_adv`.
- Arbitration:
  - If both ports are valid, grant goes to `prio`.
  - Otherwise grant goes to the valid port.
  - `reqN_ready_o` = (grant == N) & operand stage can accept & `!flush_i`. Ready is never asserted to a non-granted port.
  - `prio` flips to the other port on every accepted request when both ports were valid. It is unchanged otherwise.
- On accept, the operand stage loads rs1, rs2[4:0] (zero-extended), cmd, tag and src. `op_v` is set to 1.
- On `op_adv`, the result stage loads `sh_data_i`, tag and src. `res_v` is set to 1.
- On `res_adv` without a refill, `res_v` is cleared to 0.
- A command with none of SLL/SRL/SRA set still flows through the pipeline. Its result is 0, which the shifter produces on its own.
- `flush_i`:
  - Next cycle `op_v` = 0 and `res_v` = 0.
  - No accept occurs in the flush cycle.
  - `prio` is unchanged.
  - Outputs during the flush cycle still reflect the pre-flush state.
- The operand stage holds its contents stable while stalled. `sh_*` outputs do not change until `op_adv` or flush.

## Timing
- Reset values: `op_v` = 0, `res_v` = 0, `prio` = 0.
  - `res_valid_o` = 0, `sh_en_o` = 0, both `reqN_ready_o` = 0.
  - All data, tag and src registers = 0.
- Reset is asynchronous on assertion. Release is synchronised to `clk` by the top level. Reset mid-operation drops all in-flight operations.
- Latency: a request accepted at edge T gives `res_valid_o` = 1 after edge T+1 (two-cycle issue-to-result).
- Throughput: one operation per cycle while `res_ready_i` stays high.
- Backpressure: with `res_ready_i` low and FULL, both readies are 0.
  - One more request can be accepted from DONE, reaching FULL.
  - `res_data_o`, `res_tag_o` and `res_src_o` are stable while `res_valid_o` = 1 and `res_ready_i` = 0.
- Simultaneous drain, advance and accept in the same cycle is legal and sustains full throughput.
- Once `res_valid_o` is asserted it stays high until handshake or flush.

## Test plan
- Single SRA: port 0 sends rs1=0x8000_0010, rs2=4, cmd=SRA, tag=3; `res_ready_i`=1.
  - `res_valid_o` is high 2 cycles after accept with data=0xF800_0001, tag=3, src=0.
- Round-robin: both ports hold valid continuously; port 0 sends SLL 1<<1, port 1 sends SRL 0x100>>4.
  - Accepts alternate 0,1,0,1 starting with port 0.
  - Results alternate 0x2 and 0x10.
- Backpressure: issue 3 back-to-back SLLs (rs1=1, rs2=0,1,2) with `res_ready_i`=0.
  - First two are accepted, then both readies stay 0.
  - Raising `res_ready_i` yields results 1, 2, 4 in order, with no loss or duplication.
- Amount masking: rs1=0x1, rs2=0xFFFF_FFE3, cmd=SLL.
  - Result is 0x8 and `sh_rs2_o` = 0x3.
- Flush: flush while FULL with a request pending.
  - Next cycle `res_valid_o` = 0 and `sh_en_o` = 0.
  - The pending request is accepted one cycle after the flush and produces a correct result.
- Reset mid-operation: assert `reset_n` low asynchronously while FULL.
  - All outputs reach their reset values immediately, without waiting for a clock edge.
  - `prio` = 0 after release.
